// File: rtl/regfile_wb_queue.sv
// regfile_wb_queue: in-order write queue in front of the register file write port.
// It forwards the newest pending write to the Rs/Rt lookups.
module regfile_wb_queue #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [ADDR_W-1:0]        in_rd,
    input  logic [DATA_W-1:0]        in_data,
    input  logic                     wr_stall,
    output logic                     reg_write,
    output logic [ADDR_W-1:0]        wr_rd,
    output logic [DATA_W-1:0]        wr_data,
    input  logic [ADDR_W-1:0]        fwd_rs,
    input  logic [ADDR_W-1:0]        fwd_rt,
    output logic                     fwd_rs_hit,
    output logic                     fwd_rt_hit,
    output logic [DATA_W-1:0]        fwd_rs_data,
    output logic [DATA_W-1:0]        fwd_rt_data,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [ADDR_W-1:0] rd_q   [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];
    logic [PW-1:0]     head, tail;
    logic              enq;
    logic              empty;

    assign empty     = (count == '0);
    assign in_ready  = (count < CW'(DEPTH));
    assign enq       = in_valid && in_ready && (in_rd != '0);
    assign reg_write = !empty && !wr_stall;
    assign wr_rd     = empty ? '0 : rd_q[head];
    assign wr_data   = empty ? '0 : data_q[head];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (enq)
                tail <= tail + PW'(1);
            if (reg_write)
                head <= head + PW'(1);
            count <= count + CW'(enq) - CW'(reg_write);
        end
    end

    always_ff @(posedge clk) begin
        if (enq) begin
            rd_q[tail]   <= in_rd;
            data_q[tail] <= in_data;
        end
    end

    // Walk entries oldest to newest so the newest match overrides older ones.
    always_comb begin
        fwd_rs_hit  = 1'b0;
        fwd_rt_hit  = 1'b0;
        fwd_rs_data = '0;
        fwd_rt_data = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (CW'(i) < count && fwd_rs != '0 && rd_q[head + PW'(i)] == fwd_rs) begin
                fwd_rs_hit  = 1'b1;
                fwd_rs_data = data_q[head + PW'(i)];
            end
            if (CW'(i) < count && fwd_rt != '0 && rd_q[head + PW'(i)] == fwd_rt) begin
                fwd_rt_hit  = 1'b1;
                fwd_rt_data = data_q[head + PW'(i)];
            end
        end
    end
endmodule

// File: doc/regfile_wb_queue.md
# regfile_wb_queue

Writeback-side driver for the 32x32 register file. It accepts register write requests from the pipeline through a valid/ready handshake and buffers them in a small in-order queue. It drains them one per cycle onto the register file write port (`reg_write`, data, `Rd`). It also supplies forwarded values for in-flight writes to the `Rs`/`Rt` read side, so readers never see stale data while a write is still queued.

## Interface
- `DEPTH`, 4, number of queue entries; power of two, at least 2
- `DATA_W`, 32, register data width
- `ADDR_W`, 5, register address width
- `clk`  in  1  single clock; all state changes on the rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `in_valid`  in  1  write request present
- `in_ready`  out  1  queue can accept a request
- `in_rd`  in  ADDR_W  destination register
- `in_data`  in  DATA_W  write data
- `wr_stall`  in  1  register file cannot take a write this cycle
- `reg_write`  out  1  write strobe to the register file
- `wr_rd`  out  ADDR_W  register file `Rd`
- `wr_data`  out  DATA_W  register file data
- `fwd_rs`, `fwd_rt`  in  ADDR_W  read addresses to look up
- `fwd_rs_hit`, `fwd_rt_hit`  out  1  a pending write exists for that address
- `fwd_rs_data`, `fwd_rt_data`  out  DATA_W  newest pending data for that address; 0 when there is no hit
- `count`  out  $clog2(DEPTH)+1  number of occupied entries

## Operation
- Queue structure: circular buffer of DEPTH entries {rd, data}, with head pointer, tail pointer and an occupancy counter.
- Push: occurs when `in_valid && in_ready`.
  - `in_ready = (count < DEPTH)`.
  - A full queue does not accept a request in the same cycle as a pop; there is no pass-through.
  - A request with `in_rd == 0` is accepted and discarded: `in_ready` behaves normally and nothing is enqueued.
- Drain:
  - `reg_write = (count != 0) && !wr_stall`.
  - `wr_rd` and `wr_data` show the head entry whenever the queue is non-empty, and are 0 when it is empty.
  - A pop happens on every edge where `reg_write` is 1.
- Simultaneous push and pop: the counter is unchanged and both pointers advance.
- Ordering: strictly FIFO. Two writes to the same register reach the register file in request order.
- Forwarding (combinational):
  - Each lookup compares its address against every occupied entry, including the head entry being written this cycle.
  - When several entries match, the newest one wins.
  - A lookup of address 0 never hits.
  - A request that is on `in_*` but not yet enqueued is not forwarded.
- Pointer wrap: both pointers wrap modulo DEPTH. Entries are tracked with `count` or an occupancy bitmap, not pointer equality alone.
- Reset: asynchronous and immediate.
  - On assertion: pointers and count go to 0, all entries are invalidated, `reg_write` = 0, `in_ready` = 1, all hit outputs = 0, all data outputs = 0.
  - Writes that are pending when reset asserts are dropped.

## Timing
- Request accepted at edge N:
  - It appears in `count` and in forwarding from cycle N+1.
  - If the queue was empty and there is no stall, `reg_write` = 1 during cycle N+1, and the register file captures the write at edge N+1.
- Throughput: one push and one pop per cycle; sustained at one write per cycle with no bubbles.
- `wr_stall` acts combinationally on `reg_write` in the same cycle. The head entry holds until the stall drops.
- `in_ready` depends only on registered `count`. There is no combinational path from `in_valid` to `in_ready`.
- `rst_n` deassertion takes effect from the first rising edge after release.

## Test plan
- **Single write:** push rd=1, data=0x60C00180 at edge 0 -> `reg_write` = 1 in cycle 1 with `wr_rd` = 1 and `wr_data` = 0x60C00180; `count` returns to 0 after edge 1.
- **Fill under stall:**
  - Hold `wr_stall` = 1 and push 4 writes (rd=2..5, data=0x10..0x13) -> `count` = 4, `in_ready` = 0, and a 5th request is not accepted.
  - Release the stall -> 4 consecutive `reg_write` pulses in order rd=2,3,4,5.
- **Forwarding newest-wins:**
  - With stall held, push rd=2/0x60C00181 then rd=2/0xDEADBEEF, and set `fwd_rs` = 2, `fwd_rt` = 1 -> `fwd_rs_hit` = 1, `fwd_rs_data` = 0xDEADBEEF, `fwd_rt_hit` = 0.
  - After both entries drain, `fwd_rs_hit` = 0.
- **r0 discard:** push rd=0, data=0xFFFFFFFF -> `in_ready` = 1, `count` stays 0, no `reg_write`, and `fwd_rs` = 0 never hits.
- **Simultaneous push/pop and wrap:** stream 10 back-to-back writes (rd=1..10) with no stall -> `count` stays 1 throughout, and the `reg_write` sequence is rd=1..10 with no gaps, across pointer wrap.
- **Reset mid-operation:** with 3 entries queued and stall held, pulse `rst_n` low between edges -> `count` = 0, `reg_write` = 0 and hits = 0 immediately; after release, the first new push is the first write issued.
